// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes release of the board reset, then releases
// NUM_STAGES domain resets in index order with a programmable gap; supports soft reset and hold.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RESET | all stages in reset, waiting for synchronized reset release
// S_WAIT  | counting the gap before releasing stage idx
// S_RUN   | every stage released, o_ready high
// S_DRAIN | soft reset in progress, all stages held for SOFT_HOLD cycles
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int SYNC_DEPTH  = 2,
    parameter int STAGE_DELAY = 4,
    parameter int SOFT_HOLD   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,
    input  logic                  i_soft_rst,
    input  logic                  i_hold,
    output logic [NUM_STAGES-1:0] o_rst_n,
    output logic                  o_ready,
    output logic [1:0]            o_state
);

    localparam int CNT_MAX = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  sync_rst_n;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [NUM_STAGES-1:0] rst_q, rst_nxt;
    logic                  ready_q, ready_nxt;

    // Assertion clears the chain at once; release ripples through SYNC_DEPTH flops.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state   <= S_RESET;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            rst_q   <= rst_nxt;
            ready_q <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_q;
        ready_nxt = ready_q;

        case (state)
            S_RESET: begin
                if (sync_rst_n) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end

            S_WAIT: begin
                // Soft reset wins over both hold and a release due on this edge.
                if (i_soft_rst) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (!i_hold) begin
                    if (cnt == GAP_LAST) begin
                        rst_nxt[idx] = 1'b1;
                        cnt_nxt      = '0;
                        idx_nxt      = idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state_nxt = S_RUN;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (i_soft_rst) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                end
            end

            S_DRAIN: begin
                // A repeated request restarts the hold window; i_hold has no effect here.
                if (i_soft_rst) begin
                    cnt_nxt = '0;
                end else if (cnt == DRAIN_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    assign o_rst_n = rst_q;
    assign o_ready = ready_q;
    assign o_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected per-edge outputs are queued from the
// documented release timing, then popped and compared one edge at a time.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       soft_rst = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] rst_n;
    logic       ready;
    logic [1:0] state;

    logic       areset2_n = 1'b0;
    logic       soft2 = 1'b0;
    logic       hold2 = 1'b0;
    logic [0:0] rst2_n;
    logic       ready2;
    logic [1:0] state2;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp2_q[$];
    bit         mon_en = 1'b0;
    logic [2:0] mon_t;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .i_clk      (clk),
        .i_areset_n (areset_n),
        .i_soft_rst (soft_rst),
        .i_hold     (hold),
        .o_rst_n    (rst_n),
        .o_ready    (ready),
        .o_state    (state)
    );

    reset_sequencer #(
        .NUM_STAGES  (1),
        .SYNC_DEPTH  (3),
        .STAGE_DELAY (1),
        .SOFT_HOLD   (8)
    ) dut_p (
        .i_clk      (clk),
        .i_areset_n (areset2_n),
        .i_soft_rst (soft2),
        .i_hold     (hold2),
        .o_rst_n    (rst2_n),
        .o_ready    (ready2),
        .o_state    (state2)
    );

    // Released stages must always form a contiguous run of ones from bit 0.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_t = rst_n + 3'd1;
            checks++;
            if ((mon_t & rst_n) !== 3'd0) begin
                failures++;
                $display("FAIL order_monotonic got rst_n=%b required contiguous ones from bit 0", rst_n);
            end
        end
    end

    task automatic push_exp(input int n, input logic [2:0] r, input logic rd, input logic [1:0] s);
        for (int i = 0; i < n; i++) exp_q.push_back({r, rd, s});
    endtask

    task automatic push_power_on();
        push_exp(2, 3'b000, 1'b0, 2'd0);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(4, 3'b001, 1'b0, 2'd1);
        push_exp(4, 3'b011, 1'b0, 2'd1);
        push_exp(2, 3'b111, 1'b1, 2'd2);
    endtask

    task automatic bring_up();
        areset_n = 1'b0;
        soft_rst = 1'b0;
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        #1 areset_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        areset_n  = 1'b0;
        areset2_n = 1'b0;
        #1;
        checks++;
        if ({rst_n, ready, state} !== 6'b000_0_00) begin
            failures++;
            $display("FAIL reset_main got=%b expected=%b", {rst_n, ready, state}, 6'b000_0_00);
        end
        checks++;
        if ({rst2_n, ready2, state2} !== 4'b0_0_00) begin
            failures++;
            $display("FAIL reset_param got=%b expected=%b", {rst2_n, ready2, state2}, 4'b0_0_00);
        end
        push_exp(3, 3'b000, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL reset_held cycle %0d got=%b expected=%b", k, {rst_n, ready, state}, e);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_power_on();
        exp_t e;
        areset_n = 1'b0;
        repeat (7) @(posedge clk);
        #1 areset_n = 1'b1;
        push_power_on();
        for (int ed = 1; ed <= 16; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL power_on edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
        end
    endtask

    task automatic test_async_assert();
        exp_t e;
        #3 areset_n = 1'b0;
        #1;
        checks++;
        if ({rst_n, ready, state} !== 6'b000_0_00) begin
            failures++;
            $display("FAIL async_assert got=%b expected=%b", {rst_n, ready, state}, 6'b000_0_00);
        end
        @(posedge clk);
        #1 areset_n = 1'b1;
        push_power_on();
        for (int ed = 1; ed <= 16; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL async_rerelease edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
        end
        // Sub-cycle glitch with no clock edge inside it.
        #3 areset_n = 1'b0;
        #2 areset_n = 1'b1;
        #1;
        checks++;
        if ({rst_n, ready, state} !== 6'b000_0_00) begin
            failures++;
            $display("FAIL glitch_clear got=%b expected=%b", {rst_n, ready, state}, 6'b000_0_00);
        end
        push_power_on();
        for (int ed = 1; ed <= 16; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL glitch_restart edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        areset_n = 1'b0;
        @(posedge clk);
        #1 areset_n = 1'b1;
        push_exp(2, 3'b000, 1'b0, 2'd0);
        push_exp(7, 3'b000, 1'b0, 2'd1);
        push_exp(4, 3'b001, 1'b0, 2'd1);
        push_exp(4, 3'b011, 1'b0, 2'd1);
        push_exp(2, 3'b111, 1'b1, 2'd2);
        for (int ed = 1; ed <= 19; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL hold edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
            hold = (ed + 1 >= 5) && (ed + 1 <= 7);
        end
        hold = 1'b0;
    endtask

    task automatic test_soft_run();
        exp_t e;
        bring_up();
        soft_rst = 1'b1;
        push_exp(8, 3'b000, 1'b0, 2'd3);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(4, 3'b001, 1'b0, 2'd1);
        push_exp(4, 3'b011, 1'b0, 2'd1);
        push_exp(2, 3'b111, 1'b1, 2'd2);
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL soft_run edge N+%0d got=%b expected=%b", k, {rst_n, ready, state}, e);
            end
            soft_rst = 1'b0;
            hold = (k >= 1) && (k <= 5);
        end
        hold = 1'b0;
    endtask

    task automatic test_soft_wait();
        exp_t e;
        areset_n = 1'b0;
        soft_rst = 1'b0;
        @(posedge clk);
        #1 areset_n = 1'b1;
        push_exp(2, 3'b000, 1'b0, 2'd0);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(4, 3'b001, 1'b0, 2'd1);
        push_exp(8, 3'b000, 1'b0, 2'd3);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(1, 3'b001, 1'b0, 2'd1);
        for (int ed = 1; ed <= 23; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL soft_wait edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
            soft_rst = (ed + 1 == 11);
        end
        soft_rst = 1'b0;
    endtask

    task automatic test_soft_extend();
        exp_t e;
        bring_up();
        soft_rst = 1'b1;
        push_exp(12, 3'b000, 1'b0, 2'd3);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(1, 3'b001, 1'b0, 2'd1);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL soft_extend edge N+%0d got=%b expected=%b", k, {rst_n, ready, state}, e);
            end
            soft_rst = (k + 1 == 4);
        end
        soft_rst = 1'b0;
    endtask

    task automatic test_soft_in_reset();
        exp_t e;
        areset_n = 1'b0;
        soft_rst = 1'b1;
        @(posedge clk);
        #1 areset_n = 1'b1;
        push_exp(2, 3'b000, 1'b0, 2'd0);
        push_exp(4, 3'b000, 1'b0, 2'd1);
        push_exp(4, 3'b001, 1'b0, 2'd1);
        push_exp(4, 3'b011, 1'b0, 2'd1);
        push_exp(1, 3'b111, 1'b1, 2'd2);
        for (int ed = 1; ed <= 15; ed++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({rst_n, ready, state} !== e) begin
                failures++;
                $display("FAIL soft_in_reset edge %0d got=%b expected=%b", ed, {rst_n, ready, state}, e);
            end
            if (ed == 3) soft_rst = 1'b0;
        end
    endtask

    task automatic test_param_sweep();
        logic [3:0] e2;
        @(posedge clk);
        #1 areset2_n = 1'b1;
        for (int ed = 1; ed <= 8; ed++) begin
            if (ed >= 5)      exp2_q.push_back(4'b1_1_10);
            else if (ed == 4) exp2_q.push_back(4'b0_0_01);
            else              exp2_q.push_back(4'b0_0_00);
        end
        for (int ed = 1; ed <= 8; ed++) begin
            @(posedge clk);
            #1;
            e2 = exp2_q.pop_front();
            checks++;
            if ({rst2_n, ready2, state2} !== e2) begin
                failures++;
                $display("FAIL param_sweep edge %0d got=%b expected=%b", ed, {rst2_n, ready2, state2}, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_assert();
        test_hold();
        test_soft_run();
        test_soft_wait();
        test_soft_extend();
        test_soft_in_reset();
        test_param_sweep();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
